// File: rtl/cdb_arbiter_if.sv
// Bundles the functional-unit result requests and the registered CDB broadcast.
// master = functional units / snoopers side, slave = the arbiter.
interface cdb_arbiter_if #(
    parameter int N_REQ  = 3,
    parameter int TAG_W  = 2,
    parameter int DATA_W = 16,
    parameter int SRC_W  = $clog2(N_REQ)
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*TAG_W-1:0]  req_tag;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    cdb_hold;
    logic                    flush;
    logic                    cdb_valid;
    logic [TAG_W-1:0]        cdb_tag;
    logic [DATA_W-1:0]       cdb_data;
    logic [SRC_W-1:0]        cdb_src;

    modport master (
        output req_valid, req_tag, req_data, cdb_hold, flush,
        input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
    );

    modport slave (
        input  req_valid, req_tag, req_data, cdb_hold, flush,
        output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin common-data-bus arbiter: one functional-unit result per cycle is
// granted and broadcast on a registered, single-cycle CDB pulse.
module cdb_arbiter #(
    parameter int N_REQ  = 3,
    parameter int TAG_W  = 2,
    parameter int DATA_W = 16,
    parameter int SRC_W  = $clog2(N_REQ)
) (
    input  logic          clk,
    input  logic          rst,
    cdb_arbiter_if.slave  bus
);

    // Handshake: unit i transfers in a cycle where req_valid[i] && req_ready[i];
    // a unit keeps valid/tag/data stable until granted and may present a new
    // result the cycle after. req_ready is one-hot or zero, decided this cycle.

    logic [SRC_W-1:0]  rr_ptr;
    logic [SRC_W-1:0]  win;
    logic [SRC_W-1:0]  cand;
    logic              grant;
    logic              blocked;
    logic [N_REQ-1:0]  ready;

    logic              cdb_valid_q;
    logic [TAG_W-1:0]  cdb_tag_q;
    logic [DATA_W-1:0] cdb_data_q;
    logic [SRC_W-1:0]  cdb_src_q;

    // Explicit wrap so non-power-of-two N_REQ never visits an unused index.
    function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] p);
        if (p == SRC_W'(N_REQ - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    always_comb begin
        grant   = 1'b0;
        win     = '0;
        cand    = rr_ptr;
        ready   = '0;
        blocked = rst | bus.flush | bus.cdb_hold;
        for (int i = 0; i < N_REQ; i++) begin
            if (!grant && bus.req_valid[cand]) begin
                grant = 1'b1;
                win   = cand;
            end
            cand = wrap_inc(cand);
        end
        if (blocked) begin
            grant = 1'b0;
        end
        if (grant) begin
            ready = N_REQ'(1) << win;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
        end else if (bus.flush) begin
            // Kill the next broadcast; pointer and last payload are kept.
            cdb_valid_q <= 1'b0;
        end else if (grant) begin
            cdb_valid_q <= 1'b1;
            cdb_tag_q   <= bus.req_tag[int'(win)*TAG_W +: TAG_W];
            cdb_data_q  <= bus.req_data[int'(win)*DATA_W +: DATA_W];
            cdb_src_q   <= win;
            rr_ptr      <= wrap_inc(win);
        end else begin
            cdb_valid_q <= 1'b0;
        end
    end

    assign bus.req_ready = ready;
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_data  = cdb_data_q;
    assign bus.cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus a randomized phase, with a
// reference grant model feeding an expected-broadcast queue.
module tb_cdb_arbiter;
    localparam int N  = 3;
    localparam int TW = 2;
    localparam int DW = 16;
    localparam int SW = $clog2(N);
    localparam int W  = TW + DW + SW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW)) bus ();

    cdb_arbiter #(.N_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [N-1:0]  u_valid;
    logic [TW-1:0] u_tag  [N];
    logic [DW-1:0] u_data [N];

    int           m_ptr;
    int           last_win;
    logic [N-1:0] obs_ready;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic apply();
        bus.req_valid = u_valid;
        for (int i = 0; i < N; i++) begin
            bus.req_tag[i*TW +: TW]  = u_tag[i];
            bus.req_data[i*DW +: DW] = u_data[i];
        end
    endtask

    // Called at posedge+1 with inputs chosen; returns at the next posedge+1.
    task automatic cycle();
        int           w;
        logic         blk;
        logic [W-1:0] e;
        apply();
        #4;
        w   = -1;
        blk = rst | bus.flush | bus.cdb_hold;
        if (!blk) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (w < 0 && u_valid[c]) w = c;
            end
        end
        obs_ready = bus.req_ready;
        check("req_ready", 32'(obs_ready), (w < 0) ? 32'd0 : (32'd1 << w));
        if (w >= 0) begin
            exp_q.push_back({u_tag[w], u_data[w], SW'(w)});
            m_ptr = (w + 1) % N;
        end
        if (rst) begin
            m_ptr = 0;
            exp_q.delete();
        end
        last_win = w;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cdb_valid", 32'(bus.cdb_valid), 32'd1);
            check("cdb_word", 32'({bus.cdb_tag, bus.cdb_data, bus.cdb_src}), 32'(e));
        end else begin
            check("cdb_valid", 32'(bus.cdb_valid), 32'd0);
        end
        if (rst) begin
            check("rst_word", 32'({bus.cdb_tag, bus.cdb_data, bus.cdb_src}), 32'd0);
        end
    endtask

    task automatic idle_units();
        u_valid = '0;
        for (int i = 0; i < N; i++) begin
            u_tag[i]  = '0;
            u_data[i] = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        bus.cdb_hold = 1'b0;
        bus.flush    = 1'b0;
        m_ptr        = 0;
        last_win     = -1;
        idle_units();
        apply();
        @(posedge clk);
        #1;

        // Reset held two cycles with every unit requesting.
        u_valid = '1;
        repeat (2) begin
            cycle();
            check("rst_ready", 32'(obs_ready), 32'd0);
        end
        check("rst_valid", 32'(bus.cdb_valid), 32'd0);
        rst = 1'b0;
        idle_units();

        // Single grant to unit 1.
        u_valid   = 3'b010;
        u_tag[1]  = 2'd2;
        u_data[1] = 16'h00AB;
        cycle();
        check("single_ready", 32'(obs_ready), 32'b010);
        check("single_tag", 32'(bus.cdb_tag), 32'd2);
        check("single_data", 32'(bus.cdb_data), 32'h00AB);
        check("single_src", 32'(bus.cdb_src), 32'd1);
        u_valid = '0;
        cycle();
        check("single_pulse_end", 32'(bus.cdb_valid), 32'd0);

        // Round-robin with all units valid from reset.
        do_reset();
        for (int i = 0; i < N; i++) begin
            u_tag[i]  = TW'(i);
            u_data[i] = DW'(16'h1000 + i);
        end
        u_valid = '1;
        for (int r = 0; r < 6; r++) begin
            cycle();
            check("rr_ready", 32'(obs_ready), 32'd1 << (r % 3));
            check("rr_tag", 32'(bus.cdb_tag), 32'(r % 3));
        end
        u_valid = '0;
        cycle();

        // Wrap and skip.
        do_reset();
        u_valid = 3'b010;
        cycle();
        u_valid = 3'b001;
        u_tag[0] = 2'd3;
        cycle();
        check("wrap_ready", 32'(obs_ready), 32'b001);
        u_valid = 3'b101;
        cycle();
        check("skip_ready", 32'(obs_ready), 32'b100);
        u_valid = '0;
        cycle();

        // Hold for three cycles with unit 2 waiting.
        u_valid      = 3'b100;
        u_tag[2]     = 2'd3;
        u_data[2]    = 16'hBEEF;
        bus.cdb_hold = 1'b1;
        repeat (3) begin
            cycle();
            check("hold_ready", 32'(obs_ready), 32'd0);
            check("hold_valid", 32'(bus.cdb_valid), 32'd0);
        end
        bus.cdb_hold = 1'b0;
        cycle();
        check("hold_release_ready", 32'(obs_ready), 32'b100);
        check("hold_release_data", 32'(bus.cdb_data), 32'hBEEF);
        u_valid = '0;
        cycle();

        // Flush one cycle after a grant.
        u_valid  = 3'b001;
        u_tag[0] = 2'd1;
        cycle();
        check("flush_prev_valid", 32'(bus.cdb_valid), 32'd1);
        u_valid   = 3'b010;
        u_tag[1]  = 2'd0;
        u_data[1] = 16'h5A5A;
        bus.flush = 1'b1;
        cycle();
        check("flush_ready", 32'(obs_ready), 32'd0);
        check("flush_kill", 32'(bus.cdb_valid), 32'd0);
        bus.flush = 1'b0;
        cycle();
        check("post_flush_ready", 32'(obs_ready), 32'b010);
        check("post_flush_data", 32'(bus.cdb_data), 32'h5A5A);
        u_valid = '0;
        cycle();

        // Flush and hold together, then reset mid-stream.
        u_valid      = 3'b001;
        bus.flush    = 1'b1;
        bus.cdb_hold = 1'b1;
        cycle();
        bus.flush    = 1'b0;
        bus.cdb_hold = 1'b0;
        u_valid      = '1;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;

        // Randomized traffic honouring the hold-until-granted rule.
        last_win = -1;
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!u_valid[i] || last_win == i) begin
                    u_valid[i] = ($urandom_range(0, 99) < 50);
                    u_tag[i]   = TW'($urandom);
                    u_data[i]  = DW'($urandom);
                end
            end
            bus.cdb_hold = ($urandom_range(0, 99) < 10);
            bus.flush    = ($urandom_range(0, 99) < 5);
            rst          = ($urandom_range(0, 99) < 2);
            cycle();
        end
        rst          = 1'b0;
        bus.cdb_hold = 1'b0;
        bus.flush    = 1'b0;
        idle_units();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
